// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between a clock-divided CPU and a loader/debug host.
// Defining ARB_CPU_PAUSE_EN adds a cpu_pause input that freezes CPU ticks while host traffic continues.

module ram_arbiter #(
  parameter int CPU_DIV = 25,
  parameter int RAM_LAT = 2
) (
  input  logic        sys_clock,
  input  logic        reset,
`ifdef ARB_CPU_PAUSE_EN
  input  logic        cpu_pause,
`endif
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic        cpu_ram_cs,
  output logic        cpu_clken,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_din,
  output logic [7:0]  host_dout,
  output logic        host_ack,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        ram_rd,
  output logic        ram_wr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOST_ACC  = 2'd1,
    HOST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(CPU_DIV - 1);
  localparam logic [7:0] LAT_MAX = 8'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  lat_q, lat_d;
  logic        granted_q, granted_d;
  logic        hwe_q, hwe_d;
  logic [15:0] haddr_q, haddr_d;
  logic [7:0]  hdin_q, hdin_d;
  logic [7:0]  hdout_q, hdout_d;
  logic        pause_s, cnt_max_s, tick_s, grant_s;

`ifdef ARB_CPU_PAUSE_EN
  assign pause_s = cpu_pause;
`else
  assign pause_s = 1'b0;
`endif

  // Tick and grant decisions; granted_q limits the host to one access per CPU tick unless paused
  always_comb begin
    cnt_max_s = (cnt_q == CNT_MAX);
    tick_s    = (state_q == IDLE) && cnt_max_s && !pause_s;
    grant_s   = (state_q == IDLE) && host_req && (pause_s || (!cnt_max_s && !granted_q));
  end

  // Divider: saturates at CNT_MAX outside IDLE so a delayed tick fires on the next IDLE cycle
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_max_s) begin
      if (tick_s) begin
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Next-state logic, host request latching and read-data capture
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    granted_d = granted_q;
    hwe_d     = hwe_q;
    haddr_d   = haddr_q;
    hdin_d    = hdin_q;
    hdout_d   = hdout_q;
    if (tick_s) begin
      granted_d = 1'b0;
    end else if (grant_s) begin
      granted_d = 1'b1;
    end else begin
      granted_d = granted_q;
    end
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = HOST_ACC;
          lat_d   = 8'd0;
          hwe_d   = host_we;
          haddr_d = host_addr;
          hdin_d  = host_din;
        end else begin
          state_d = IDLE;
        end
      end
      HOST_ACC: begin
        if (lat_q == LAT_MAX) begin
          state_d = HOST_DONE;
          if (!hwe_q) begin
            hdout_d = ram_dout;
          end else begin
            hdout_d = hdout_q;
          end
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      HOST_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM port mux: host owns the bus only while an access is in flight
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_rd   = cpu_ram_cs;
    ram_wr   = cpu_we & cpu_ram_cs & tick_s;
    if (state_q == HOST_ACC) begin
      ram_addr = haddr_q;
      ram_din  = hdin_q;
      ram_rd   = !hwe_q;
      ram_wr   = hwe_q;
    end else begin
      ram_addr = cpu_addr;
    end
  end

  assign cpu_clken = tick_s;
  assign host_ack  = (state_q == HOST_DONE);
  assign host_dout = hdout_q;

  // State registers; reset aborts any host access immediately
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      lat_q     <= 8'd0;
      granted_q <= 1'b0;
      hwe_q     <= 1'b0;
      haddr_q   <= 16'h0000;
      hdin_q    <= 8'h00;
      hdout_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      granted_q <= granted_d;
      hwe_q     <= hwe_d;
      haddr_q   <= haddr_d;
      hdin_q    <= hdin_d;
      hdout_q   <= hdout_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vectors, corner sequences and a randomized
// run compared against a cycle model built from the arbitration rules.

module tb_ram_arbiter;

  localparam int DIV = 25;
  localparam int LAT = 2;

  logic        sys_clock, reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we, cpu_ram_cs, cpu_clken;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_din, host_dout;
  logic        host_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_rd, ram_wr;
`ifdef ARB_CPU_PAUSE_EN
  logic        cpu_pause;
`endif

  ram_arbiter #(.CPU_DIV(DIV), .RAM_LAT(LAT)) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
`ifdef ARB_CPU_PAUSE_EN
    .cpu_pause (cpu_pause),
`endif
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_we    (cpu_we),
    .cpu_ram_cs(cpu_ram_cs),
    .cpu_clken (cpu_clken),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_dout (host_dout),
    .host_ack  (host_ack),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_rd    (ram_rd),
    .ram_wr    (ram_wr)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  // Behavioural RAM: combinational read, write on the rising edge
  logic [7:0] mem [0:1023];
  logic       mem_clr;
  assign ram_dout = mem[ram_addr[9:0]];
  always @(posedge sys_clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (ram_wr) begin
      mem[ram_addr[9:0]] <= ram_din;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clock);
  endtask

  task automatic idle_inputs();
    cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0; cpu_ram_cs = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_din = 8'h00;
  endtask

  // Holds reset for two cycles, checks the reset state, releases at a falling edge
  task automatic do_reset(input logic clr);
    reset = 1'b1;
    mem_clr = clr;
    idle_inputs();
    cyc();
    #1;
    chk("rst_clken", 32'(cpu_clken), 32'd0);
    chk("rst_ack", 32'(host_ack), 32'd0);
    chk("rst_hdout", 32'(host_dout), 32'h00);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    cyc();
    reset = 1'b0;
    mem_clr = 1'b0;
  endtask

  // Reference model: integer counter, remaining-busy countdown and a shadow memory
  int          m_cnt, m_busy;
  bit          m_granted;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_din, m_dout;
  logic [7:0]  ref_mem [0:1023];

  task automatic model_cycle();
    bit          idle, acc, done, e_clk, grant;
    logic [15:0] e_addr;
    logic [7:0]  e_din;
    logic        e_rd, e_wr;
    idle  = (m_busy == 0);
    done  = (m_busy == 1);
    acc   = (m_busy > 1);
    e_clk = idle && (m_cnt == DIV - 1);
    if (acc) begin
      e_addr = m_addr; e_din = m_din; e_rd = !m_we; e_wr = m_we;
    end else begin
      e_addr = cpu_addr; e_din = cpu_dout; e_rd = cpu_ram_cs;
      e_wr = cpu_we & cpu_ram_cs & e_clk;
    end
    chk("m_clken", 32'(cpu_clken), 32'(e_clk));
    chk("m_ack", 32'(host_ack), 32'(done));
    chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("m_ram_din", 32'(ram_din), 32'(e_din));
    chk("m_ram_rd", 32'(ram_rd), 32'(e_rd));
    chk("m_ram_wr", 32'(ram_wr), 32'(e_wr));
    chk("m_hdout", 32'(host_dout), 32'(m_dout));
    grant = idle && host_req && (m_cnt != DIV - 1) && !m_granted;
    if (m_busy == 2 && !m_we) m_dout = ref_mem[m_addr[9:0]];
    if (acc && m_we) ref_mem[m_addr[9:0]] = m_din;
    if (e_clk && cpu_we && cpu_ram_cs) ref_mem[cpu_addr[9:0]] = cpu_dout;
    if (idle) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
    else if (m_cnt < DIV - 1) m_cnt = m_cnt + 1;
    if (e_clk) m_granted = 1'b0;
    if (grant) begin
      m_busy = LAT + 1; m_granted = 1'b1;
      m_we = host_we; m_addr = host_addr; m_din = host_din;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic        cs;
    logic [15:0] e_addr;
    logic [7:0]  e_din;
    logic        e_rd;
    logic        e_wr;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [15:0] e_addr;
    logic [7:0]  e_din, e_hd;
    logic        e_rd, e_wr;
    int          last_tick, acks, np, na;
    bit          ack_seen, found;

    // CPU-side mux vectors applied in IDLE away from a tick, so writes stay gated
    vt[0] = '{16'h0200, 8'h11, 1'b0, 1'b1, 16'h0200, 8'h11, 1'b1, 1'b0};
    vt[1] = '{16'h02AB, 8'h22, 1'b1, 1'b1, 16'h02AB, 8'h22, 1'b1, 1'b0};
    vt[2] = '{16'h0300, 8'h33, 1'b1, 1'b0, 16'h0300, 8'h33, 1'b0, 1'b0};
    vt[3] = '{16'hFFFF, 8'hFF, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 1'b0, 1'b0};
    vt[4] = '{16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0};
    vt[5] = '{16'h1234, 8'h5A, 1'b1, 1'b1, 16'h1234, 8'h5A, 1'b1, 1'b0};

`ifdef ARB_CPU_PAUSE_EN
    cpu_pause = 1'b0;
`endif
    reset = 1'b1;
    mem_clr = 1'b1;
    idle_inputs();
    do_reset(1'b1);

    // Tick cadence, table vectors, host write at counter 3, host read at counter 24
    for (int k = 0; k <= 100; k++) begin
      idle_inputs();
      host_req  = (k >= 3 && k <= 6) || (k >= 74 && k <= 78);
      host_we   = (k <= 6);
      host_addr = 16'h0280;
      host_din  = 8'h5A;
      e_addr = 16'h0000; e_din = 8'h00; e_rd = 1'b0; e_wr = 1'b0;
      if (k >= 8 && k < 14) begin
        cpu_addr = vt[k-8].addr; cpu_dout = vt[k-8].dout;
        cpu_we = vt[k-8].we; cpu_ram_cs = vt[k-8].cs;
        e_addr = vt[k-8].e_addr; e_din = vt[k-8].e_din;
        e_rd = vt[k-8].e_rd; e_wr = vt[k-8].e_wr;
      end else if (k == 90) begin
        cpu_addr = 16'h0280; cpu_ram_cs = 1'b1;
        e_addr = 16'h0280; e_rd = 1'b1;
      end else begin
        e_rd = 1'b0;
      end
      if (k == 4 || k == 5) begin
        e_addr = 16'h0280; e_din = 8'h5A; e_rd = 1'b0; e_wr = 1'b1;
      end
      if (k == 76 || k == 77) begin
        e_addr = 16'h0280; e_din = 8'h5A; e_rd = 1'b1; e_wr = 1'b0;
      end
      e_hd = (k >= 78) ? 8'h5A : 8'h00;
      #1;
      chk($sformatf("seq_clken_k%0d", k), 32'(cpu_clken), 32'((k % DIV) == DIV - 1));
      chk($sformatf("seq_ack_k%0d", k), 32'(host_ack), 32'(k == 6 || k == 78));
      chk($sformatf("seq_ram_addr_k%0d", k), 32'(ram_addr), 32'(e_addr));
      chk($sformatf("seq_ram_din_k%0d", k), 32'(ram_din), 32'(e_din));
      chk($sformatf("seq_ram_rd_k%0d", k), 32'(ram_rd), 32'(e_rd));
      chk($sformatf("seq_ram_wr_k%0d", k), 32'(ram_wr), 32'(e_wr));
      chk($sformatf("seq_hdout_k%0d", k), 32'(host_dout), 32'(e_hd));
      if (k == 90) chk("cpu_read_after_host_write", 32'(ram_dout), 32'h5A);
      cyc();
    end

    // Host request held continuously: one ack per tick window, tick period intact
    do_reset(1'b0);
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0281;
    last_tick = -1; acks = 0;
    for (int k = 0; k < 160; k++) begin
      #1;
      chk("ack_clken_exclusive", 32'(host_ack & cpu_clken), 32'd0);
      if (host_ack) acks++;
      if (cpu_clken) begin
        if (last_tick >= 0) begin
          chk("held_req_tick_period", 32'(k - last_tick), 32'(DIV));
          chk("held_req_acks_per_tick", 32'(acks), 32'd1);
        end
        acks = 0;
        last_tick = k;
      end
      cyc();
    end
    chk("held_req_ticks_seen", 32'(last_tick >= 0), 32'd1);

    // Reset in the second HOST_ACC cycle of a write
    do_reset(1'b0);
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0300; host_din = 8'hA5;
    cyc();
    #1;
    chk("abort_acc1_wr", 32'(ram_wr), 32'd1);
    cyc();
    #1;
    chk("abort_acc2_wr", 32'(ram_wr), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_wr_drops", 32'(ram_wr), 32'd0);
    chk("abort_no_ack", 32'(host_ack), 32'd0);
    chk("abort_clken", 32'(cpu_clken), 32'd0);
    cyc();
    reset = 1'b0;
    host_req = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      chk($sformatf("abort_post_ack_k%0d", k), 32'(host_ack), 32'd0);
      chk($sformatf("abort_post_clken_k%0d", k), 32'(cpu_clken), 32'(k == DIV - 1));
      cyc();
    end

`ifdef ARB_CPU_PAUSE_EN
    // Paused CPU: host accesses run back to back, tick resumes right after release
    do_reset(1'b0);
    cpu_pause = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0201;
    np = 0; na = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (cpu_clken) np++;
      if (host_ack) na++;
      cyc();
    end
    chk("pause_no_clken", 32'(np), 32'd0);
    chk("pause_back_to_back", 32'(na >= 100 / (LAT + 2) - 1), 32'd1);
    cpu_pause = 1'b0;
    host_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      #1;
      if (cpu_clken) found = 1'b1;
      cyc();
    end
    chk("pause_release_tick", 32'(found), 32'd1);
`else
    np = 0; na = 0; found = 1'b0;
`endif

    // Randomized traffic against the reference model
    do_reset(1'b1);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
    m_cnt = 0; m_busy = 0; m_granted = 1'b0; m_dout = 8'h00;
    m_we = 1'b0; m_addr = 16'h0000; m_din = 8'h00;
    ack_seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (ack_seen) host_req = 1'b0;
      if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req  = 1'b1;
        host_we   = 1'($urandom_range(0, 1));
        host_addr = 16'h0200 + 16'($urandom_range(0, 15));
        host_din  = 8'($urandom);
      end
      cpu_addr   = 16'h0200 + 16'($urandom_range(0, 15));
      cpu_dout   = 8'($urandom);
      cpu_we     = 1'($urandom_range(0, 1));
      cpu_ram_cs = ($urandom_range(0, 3) != 0);
      #1;
      model_cycle();
      ack_seen = host_ack;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
